// File: rtl/if_stage.sv
// RV32I fetch stage: PC, imem requests, fetch FIFO, redirect flush.
// Optional IF_MISALIGN_CHECK_EN adds misalign_o/misalign_pc_o.
//
// Ports: clk_i, rst_i (sync, active-high);
//   imem_req_o/addr_o/gnt_i/rvalid_i/rdata_i (fetch bus);
//   redirect_i/redirect_pc_i (from execute);
//   inst_o/pc_o/inst_valid_o/inst_ready_i (to decode).
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o,
  output logic [31:0] misalign_pc_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   tag_pc;
  logic [31:0]   last_pc;
  logic          outstanding;
  logic          kill;
  logic          halt;

  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [4:0]    credit;
  logic          resp;
  logic          push;
  logic          pop;
  logic          req_fire;
  logic          out_nxt;
  logic          bad_tgt;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef IF_MISALIGN_CHECK_EN
  assign bad_tgt = redirect_pc_i[1:0] != 2'b00;
`else
  assign bad_tgt = 1'b0;
`endif

  // A response is only meaningful while we own one in flight.
  assign resp = imem_rvalid_i & outstanding;
  assign push = resp & ~kill;

  assign inst_valid_o = count != '0;
  assign pop          = inst_valid_o & inst_ready_i;

  // Credit: buffered + in flight, minus what leaves this cycle.
  assign credit = 5'(count) + 5'(outstanding) - 5'(pop);

  assign imem_req_o = (state == RUN) & ~redirect_i
                    & (credit < 5'(FIFO_DEPTH));
  assign imem_addr_o = pc;
  assign req_fire    = imem_req_o & imem_gnt_i;
  assign out_nxt     = req_fire | (outstanding & ~resp);

  assign inst_o = inst_valid_o ? fifo_inst[rd_ptr] : NOP_INST;
  assign pc_o   = inst_valid_o ? fifo_pc[rd_ptr]   : last_pc;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata_i;
      fifo_pc[wr_ptr]   <= tag_pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      tag_pc      <= '0;
      last_pc     <= '0;
      outstanding <= 1'b0;
      kill        <= 1'b0;
      halt        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (inst_valid_o) last_pc <= pc_o;
      if (redirect_i) begin
        state       <= FLUSH;
        pc          <= redirect_pc_i & ~32'h3;
        outstanding <= out_nxt;
        kill        <= out_nxt;
        halt        <= bad_tgt;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
      end else begin
        if (req_fire) begin
          pc     <= pc + 32'd4;
          tag_pc <= pc;
        end
        outstanding <= out_nxt;
        if (resp) kill <= 1'b0;
        if (push) wr_ptr <= inc(wr_ptr);
        if (pop) rd_ptr <= inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
        unique case (state)
          IDLE:    state <= RUN;
          RUN:     state <= RUN;
          FLUSH:   state <= halt ? FLUSH : RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_o    <= 1'b0;
      misalign_pc_o <= '0;
    end else begin
      misalign_o <= redirect_i & bad_tgt;
      if (redirect_i & bad_tgt)
        misalign_pc_o <= redirect_pc_i;
    end
  end
`endif

endmodule
